serial_signed_compare: RTL and testbench

//  Bit-serial two's-complement magnitude comparator for the Basic ALU datapath.

---
 rtl/serial_signed_compare.sv | 95 +++++++++
 tb/tb_serial_signed_compare.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_signed_compare.sv
// Bit-serial two's-complement comparator: operands arrive MSB (sign) first, one
// bit pair per accepted beat; after WIDTH beats great/less/equal are updated.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; last result held on great/less/equal
//   SCAN  | accepting beats, busy=1; first differing bit pair decides
//   DONE  | one cycle, done=1; result flags were just updated
module serial_signed_compare #(
   parameter int WIDTH = 6,
   parameter int RES_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             busy,
   output logic             done,
   output logic [RES_W-1:0] great,
   output logic [RES_W-1:0] less,
   output logic [RES_W-1:0] equal
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   typedef enum logic [1:0] {UNDEC, DEC_GT, DEC_LT} dec_t;

   state_t  state;
   dec_t    dec;
   dec_t    dec_nxt;
   logic [CW-1:0] cnt;
   logic    last_beat;

   assign last_beat = (cnt == CW'(WIDTH - 1));

   // On the sign beat a set bit means negative, so the polarity is inverted.
   always_comb begin
      dec_nxt = dec;
      if (dec == UNDEC && a_bit != b_bit) begin
         if (cnt == '0)
            dec_nxt = a_bit ? DEC_LT : DEC_GT;
         else
            dec_nxt = a_bit ? DEC_GT : DEC_LT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         great <= '0;
         less  <= '0;
         equal <= '0;
         cnt   <= '0;
         dec   <= UNDEC;
      end else if (start) begin
         state <= SCAN;
         busy  <= 1'b1;
         done  <= 1'b0;
         cnt   <= '0;
         dec   <= UNDEC;
      end else begin
         case (state)
            SCAN: begin
               if (bit_valid) begin
                  cnt <= cnt + CW'(1);
                  dec <= dec_nxt;
                  if (last_beat) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     great <= RES_W'(dec_nxt == DEC_GT);
                     less  <= RES_W'(dec_nxt == DEC_LT);
                     equal <= RES_W'(dec_nxt == UNDEC);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_signed_compare.sv
// Directed bench for serial_signed_compare: a vector table of operand pairs with
// hand-computed results, plus restart and asynchronous-reset sequences.
module tb_serial_signed_compare;

   localparam int W = 6;
   localparam int R = 6;

   logic clk = 1'b0;
   logic reset, start, bit_valid, a_bit, b_bit;
   logic busy, done;
   logic [R-1:0] great, less, equal;

   int total = 0;
   int bad   = 0;
   int done_pulses = 0;

   serial_signed_compare #(.WIDTH(W), .RES_W(R)) dut (
      .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
      .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
      .great(great), .less(less), .equal(equal)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_pulses++;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           gap;
      int           ncyc;
      logic [2:0]   gle;   // expected {great, less, equal}
   } vec_t;

   vec_t vecs[10];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_flags(input string name, input logic [2:0] gle);
      chk({name, ".great"}, 32'(great), 32'(gle[2]));
      chk({name, ".less"},  32'(less),  32'(gle[1]));
      chk({name, ".equal"}, 32'(equal), 32'(gle[0]));
   endtask

   task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                          output int ncyc, output bit busy_ok);
      ncyc = 0;
      busy_ok = 1'b1;
      start = 1'b1;
      bit_valid = 1'b0;
      cyc();
      ncyc++;
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i == 2) begin
            for (int g = 0; g < gap; g++) begin
               bit_valid = 1'b0;
               cyc();
               ncyc++;
               if (busy !== 1'b1) busy_ok = 1'b0;
            end
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         bit_valid = 1'b1;
         a_bit = a[W-1-i];
         b_bit = b[W-1-i];
         cyc();
         ncyc++;
      end
      bit_valid = 1'b0;
      while (done !== 1'b1 && ncyc < 40) begin
         cyc();
         ncyc++;
      end
   endtask

   initial begin
      int  n;
      bit  bok;
      int  pulses0;
      logic [W-1:0] ta, tb;

      vecs[0] = '{6'b011111, 6'b100000, 0,  7, 3'b100};
      vecs[1] = '{6'b111111, 6'b111110, 0,  7, 3'b100};
      vecs[2] = '{6'b111110, 6'b111111, 0,  7, 3'b010};
      vecs[3] = '{6'b000101, 6'b000101, 0,  7, 3'b001};
      vecs[4] = '{6'b100000, 6'b011111, 0,  7, 3'b010};
      vecs[5] = '{6'b011111, 6'b100000, 3, 10, 3'b100};
      vecs[6] = '{6'b000000, 6'b000000, 0,  7, 3'b001};
      vecs[7] = '{6'b111111, 6'b000000, 0,  7, 3'b010};
      vecs[8] = '{6'b000000, 6'b111111, 0,  7, 3'b100};
      vecs[9] = '{6'b000001, 6'b000000, 0,  7, 3'b100};

      reset = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      cyc(); cyc();
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk_flags("rst", 3'b000);
      reset = 1'b0;
      cyc();

      for (int v = 0; v < 10; v++) begin
         run_cmp(vecs[v].a, vecs[v].b, vecs[v].gap, n, bok);
         chk($sformatf("v%0d.latency", v), 32'(n), 32'(vecs[v].ncyc));
         chk($sformatf("v%0d.busy_held", v), 32'(bok), 1);
         chk($sformatf("v%0d.done", v), 32'(done), 1);
         chk($sformatf("v%0d.busy_in_done", v), 32'(busy), 0);
         chk_flags($sformatf("v%0d", v), vecs[v].gle);
         cyc();
         chk($sformatf("v%0d.done_pulse", v), 32'(done), 0);
         chk_flags($sformatf("v%0d.hold", v), vecs[v].gle);
      end

      // Restart mid-scan: abandoned A=5,B=3 after 3 beats, then A=-4,B=2.
      pulses0 = done_pulses;
      ta = 6'b000101; tb = 6'b000011;
      start = 1'b1; cyc(); start = 1'b0;
      chk_flags("restart.keep_old", 3'b100);
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1; a_bit = ta[W-1-i]; b_bit = tb[W-1-i];
         cyc();
      end
      chk("restart.busy", 32'(busy), 1);
      run_cmp(6'b111100, 6'b000010, 0, n, bok);
      chk("restart.latency", 32'(n), 7);
      chk_flags("restart", 3'b010);
      cyc(); cyc(); cyc();
      chk("restart.pulses", 32'(done_pulses - pulses0), 1);

      // Asynchronous reset mid-scan.
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1;
         cyc();
      end
      #2 reset = 1'b1;
      #1;
      chk("arst.busy", 32'(busy), 0);
      chk("arst.done", 32'(done), 0);
      chk_flags("arst", 3'b000);
      cyc();
      reset = 1'b0;
      pulses0 = done_pulses;
      for (int i = 0; i < 2 * W; i++) begin
         bit_valid = 1'b1; a_bit = i[0]; b_bit = ~i[0];
         cyc();
      end
      bit_valid = 1'b0;
      cyc();
      chk("arst.nostart_busy", 32'(busy), 0);
      chk("arst.nostart_pulses", 32'(done_pulses - pulses0), 0);
      chk_flags("arst.nostart", 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
